gold_nic: RTL
=============

# gold_nic

Network interface controller between a processor core and the PE port of `gold_router`. The processor reads and writes four memory-mapped registers. The NIC holds one outbound packet, which it injects into the router PE input, and one inbound packet, which it accepts from the router PE output. All processor-visible state is registered. Router-side handshakes follow the router's send/ready convention, and injection is gated by router polarity.

## Interface
Parameters:
- `DATA_W`, default 64: packet and register data width.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `addr`  in  2  register select: 00 in-buffer, 01 in-status, 10 out-buffer, 11 out-status.
- `d_in`  in  64  processor write data.
- `d_out`  out  64  processor read data, registered.
- `nicEn`  in  1  register access enable.
- `nicWrEn`  in  1  1 = write, 0 = read (qualified by `nicEn`).
- `net_so`  out  1  send to router PE input (drives router `pesi`).
- `net_ro`  in  1  router PE input ready (router `peri`).
- `net_do`  out  64  packet to router (router `pedi`).
- `net_si`  in  1  router PE output send (router `peso`).
- `net_ri`  out  1  NIC ready to accept (router `pero`).
- `net_di`  in  64  packet from router (router `pedo`).
- `net_polarity`  in  1  router polarity output.

## Operation
State:
- `in_buf[63:0]`, `in_full`.
- `out_buf[63:0]`, `out_full`.
- `d_out` register.
- `ovf` flag, only with the macro.

Reset values: `in_buf`, `out_buf`, `d_out` = 0; `in_full`, `out_full`, `ovf` = 0. Consequently `net_so` = 0, `net_ri` = 1, `net_do` = 0.

Inbound path:
- `net_ri = ~in_full`.
- On `net_si & net_ri`: `in_buf <= net_di`, `in_full <= 1`.
- `net_si` while `in_full = 1` is a router protocol violation; data is ignored and `in_buf` is unchanged.

Outbound path:
- `net_so = out_full & net_ro & (net_polarity == out_buf[63])`, combinational. A packet is injected only in the cycle whose polarity matches its VC bit.
- `net_do = out_buf`.
- On `net_so`: `out_full <= 0`; `out_buf` is retained.

Processor reads (`nicEn & ~nicWrEn`), with `d_out` updated at the edge:
- 00: `d_out <= in_buf`. If `in_full`, then `in_full <= 0`. Reading when empty returns stale `in_buf` and leaves `in_full = 0`.
- 01: `d_out <= {62'b0, ovf, in_full}`.
- 10: `d_out <= out_buf`, no side effects.
- 11: `d_out <= {62'b0, ovf, out_full}`.
- With `nicEn = 0`, `d_out` holds its value.

Processor writes (`nicEn & nicWrEn`):
- 10, accepted if `out_full = 0` or `net_so = 1` this cycle: `out_buf <= d_in`, `out_full <= 1`.
- 10, otherwise: dropped, buffer unchanged.
- 00, 01, 11: ignored.

Simultaneous events:
- In-buffer read at address 00 clears `in_full` at the same edge. A new inbound packet can be accepted on the following cycle at the earliest, because `net_ri` was 0 during the read cycle.
- Write to 10 in the same cycle as `net_so`: the new packet is loaded and `out_full` stays 1.

## Timing
- Read latency: 1 cycle; `d_out` is valid after the edge on which `nicEn` is sampled.
- Write-to-`net_so` latency: at least 1 cycle. `out_full` rises at the write edge, and `net_so` asserts in the first later cycle with `net_ro = 1` and matching polarity. Maximum wait with `net_ro` held high is 2 cycles.
- Router-to-status latency: a packet accepted at edge N shows `in_full = 1` on a status read issued in cycle N+1, with data at N+2.
- Asynchronous reset mid-transfer drops any pending packet. `net_so` deasserts immediately and `net_ri` asserts immediately.

## Configuration
- `GOLD_NIC_OVF_EN` defined:
  - `ovf` sets to 1 on a dropped write to address 10.
  - `ovf` is sticky and reads as bit 1 of both status registers.
  - `ovf` is cleared only by a write of any data to address 11.
- `GOLD_NIC_OVF_EN` undefined:
  - No `ovf` register; status bit 1 reads 0.
  - Writes to 11 are ignored.

## Test plan
- Reset deasserted, no activity: `net_ri = 1`, `net_so = 0`, `d_out = 0`; status reads at 01 and 11 return 0.
- Write `0x8000_0000_0000_00AA` to 10 with `net_ro = 1`, polarity toggling: `net_so` pulses exactly once, in a cycle with `net_polarity = 1`, with `net_do` = that value. Out-status then reads 0.
- Router drives `net_si = 1` with `net_di = 0x0000_0000_0000_1234`: `net_ri` falls the next cycle. Read 01 returns 1. Read 00 returns `0x1234` and clears `in_full`. The next read at 01 returns 0.
- With `out_full = 1` and `net_ro = 0`, write `0x55` to 10: buffer keeps the old packet. With macro: status 11 returns `0x3`, then a write to 11 clears `ovf`. Without macro: status 11 returns `0x1`.
- With `out_full = 1`, `net_so = 1` this cycle, write `0x77` to 10 in the same cycle: the old packet is sent, `out_buf = 0x77`, `out_full` stays 1.
- Assert `reset` asynchronously while `out_full = 1` and `in_full = 1`: all flags read 0, `net_so = 0`, and `net_ri = 1` before the next edge.

Source files
------------

// File: rtl/gold_nic.sv
// gold_nic: processor-facing NIC with one inbound and one outbound packet buffer for the gold_router PE port.
// Optional sticky overflow flag is enabled by defining GOLD_NIC_OVF_EN.
module gold_nic #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  input  logic              net_polarity
);

  localparam logic [1:0] A_IN_BUF  = 2'b00;
  localparam logic [1:0] A_IN_ST   = 2'b01;
  localparam logic [1:0] A_OUT_BUF = 2'b10;
  localparam logic [1:0] A_OUT_ST  = 2'b11;

  logic [DATA_W-1:0] in_buf;
  logic [DATA_W-1:0] out_buf;
  logic              in_full;
  logic              out_full;
  logic              ovf;
  logic              rd_en;
  logic              wr_en;

  assign rd_en  = nicEn & ~nicWrEn;
  assign wr_en  = nicEn & nicWrEn;
  assign net_ri = ~in_full;
  assign net_do = out_buf;
  // The MSB of the packet is its VC bit; injection waits for the matching router phase.
  assign net_so = out_full & net_ro & (net_polarity == out_buf[DATA_W-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_buf   <= '0;
      in_full  <= 1'b0;
      out_buf  <= '0;
      out_full <= 1'b0;
      d_out    <= '0;
    end else begin
      if (net_si && !in_full) begin
        in_buf  <= net_di;
        in_full <= 1'b1;
      end

      if (net_so)
        out_full <= 1'b0;

      if (rd_en) begin
        case (addr)
          A_IN_BUF: begin
            d_out <= in_buf;
            if (in_full)
              in_full <= 1'b0;
          end
          A_IN_ST:   d_out <= {{(DATA_W-2){1'b0}}, ovf, in_full};
          A_OUT_BUF: d_out <= out_buf;
          A_OUT_ST:  d_out <= {{(DATA_W-2){1'b0}}, ovf, out_full};
          default:   d_out <= d_out;
        endcase
      end

      // A write landing in the same cycle as an injection reloads the buffer and keeps it full.
      if (wr_en && addr == A_OUT_BUF && (!out_full || net_so)) begin
        out_buf  <= d_in;
        out_full <= 1'b1;
      end
    end
  end

`ifdef GOLD_NIC_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovf <= 1'b0;
    else if (wr_en && addr == A_OUT_BUF && out_full && !net_so)
      ovf <= 1'b1;
    else if (wr_en && addr == A_OUT_ST)
      ovf <= 1'b0;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
